// File: rtl/cpu_pkg.sv
// Shared CPU package: datapath widths, memory access-size and writeback-source encodings.
// Imported by the pipeline stages and the alignment checker.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 16;
    localparam int RF_AW  = 5;

    // Memory access size select
    localparam logic [1:0] MEM_SEL_B = 2'b00;
    localparam logic [1:0] MEM_SEL_H = 2'b01;
    localparam logic [1:0] MEM_SEL_W = 2'b11;

    // Writeback source select
    localparam logic [1:0] WB_SEL_ALU = 2'b00;
    localparam logic [1:0] WB_SEL_MEM = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

endpackage

// File: rtl/mem_align_chk.sv
// Combinational alignment check for a data memory access.
// Ports: adr_i[1:0] low address bits, sel_i access size, access_i access is live,
//        misalign_o access is misaligned or uses the illegal size code 2'b10.
module mem_align_chk
    import cpu_pkg::*;
(
    input  logic [1:0] adr_i,
    input  logic [1:0] sel_i,
    input  logic       access_i,
    output logic       misalign_o
);

    always_comb begin
        misalign_o = 1'b0;
        if (access_i) begin
            case (sel_i)
                MEM_SEL_B: misalign_o = 1'b0;
                MEM_SEL_H: misalign_o = adr_i[0];
                MEM_SEL_W: misalign_o = |adr_i;
                default:   misalign_o = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: latches EX results/control, qualifies stores and writebacks
// against bubbles and misalignment, and exposes load-use info to the hazard unit.
// Ports: clk_i, reset_i (async, active-high), stall_i, flush_i, EX-side *_i fields,
//        MEM-side *_o fields, misalign_o, load_in_mem_o, load_cnt_o, store_cnt_o.
// Optional: define MEM_ACCESS_CNT_EN to build the load/store access counters.
module ex_mem_reg #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int ADDR_W = cpu_pkg::ADDR_W,
    parameter int RF_AW  = cpu_pkg::RF_AW
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              stall_i,
    input  logic              flush_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] alu_res_i,
    input  logic [DATA_W-1:0] st_data_i,
    input  logic              mem_we_i,
    input  logic              mem_re_i,
    input  logic [1:0]        mem_data_sel_i,
    input  logic [1:0]        wb_sel_i,
    input  logic              reg_we_i,
    input  logic [RF_AW-1:0]  rd_i,
    input  logic [DATA_W-1:0] pc4_i,
    output logic              valid_o,
    output logic [ADDR_W-1:0] adr_o,
    output logic [DATA_W-1:0] alu_res_o,
    output logic [DATA_W-1:0] st_data_o,
    output logic              mem_we_o,
    output logic [1:0]        mem_data_sel_o,
    output logic [1:0]        wb_sel_o,
    output logic              reg_we_o,
    output logic [RF_AW-1:0]  rd_o,
    output logic [DATA_W-1:0] pc4_o,
    output logic              misalign_o,
    output logic              load_in_mem_o,
    output logic [31:0]       load_cnt_o,
    output logic [31:0]       store_cnt_o
);

    logic              valid_r;
    logic [DATA_W-1:0] alu_res_r;
    logic [DATA_W-1:0] st_data_r;
    logic              mem_we_r;
    logic              mem_re_r;
    logic [1:0]        sel_r;
    logic [1:0]        wb_sel_r;
    logic              reg_we_r;
    logic [RF_AW-1:0]  rd_r;
    logic [DATA_W-1:0] pc4_r;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            valid_r   <= 1'b0;
            alu_res_r <= '0;
            st_data_r <= '0;
            mem_we_r  <= 1'b0;
            mem_re_r  <= 1'b0;
            sel_r     <= '0;
            wb_sel_r  <= '0;
            reg_we_r  <= 1'b0;
            rd_r      <= '0;
            pc4_r     <= '0;
        end else if (flush_i) begin
            valid_r   <= 1'b0;
            alu_res_r <= '0;
            st_data_r <= '0;
            mem_we_r  <= 1'b0;
            mem_re_r  <= 1'b0;
            sel_r     <= '0;
            wb_sel_r  <= '0;
            reg_we_r  <= 1'b0;
            rd_r      <= '0;
            pc4_r     <= '0;
        end else if (!stall_i) begin
            valid_r   <= valid_i;
            alu_res_r <= alu_res_i;
            st_data_r <= st_data_i;
            mem_we_r  <= valid_i & mem_we_i;
            // A store that also claims to read is handled as a pure store
            mem_re_r  <= valid_i & mem_re_i & ~mem_we_i;
            sel_r     <= mem_data_sel_i;
            wb_sel_r  <= wb_sel_i;
            reg_we_r  <= valid_i & reg_we_i;
            rd_r      <= rd_i;
            pc4_r     <= pc4_i;
        end
    end

    logic mis;

    mem_align_chk u_align (
        .adr_i      (alu_res_r[1:0]),
        .sel_i      (sel_r),
        .access_i   (valid_r & (mem_we_r | mem_re_r)),
        .misalign_o (mis)
    );

    assign valid_o        = valid_r;
    assign adr_o          = alu_res_r[ADDR_W-1:0];
    assign alu_res_o      = alu_res_r;
    assign st_data_o      = st_data_r;
    assign mem_data_sel_o = sel_r;
    assign wb_sel_o       = wb_sel_r;
    assign pc4_o          = pc4_r;
    assign misalign_o     = mis;
    assign mem_we_o       = valid_r & mem_we_r & ~mis;
    assign reg_we_o       = valid_r & reg_we_r & ~(mem_re_r & mis);
    assign rd_o           = reg_we_o ? rd_r : '0;
    assign load_in_mem_o  = valid_r & mem_re_r & ~mis;

`ifdef MEM_ACCESS_CNT_EN
    logic [31:0] load_cnt_r;
    logic [31:0] store_cnt_r;

    // An access counts on the cycle it leaves MEM, so a stalled one counts once
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            load_cnt_r  <= '0;
            store_cnt_r <= '0;
        end else if (!stall_i) begin
            if (load_in_mem_o)
                load_cnt_r <= load_cnt_r + 32'd1;
            if (mem_we_o)
                store_cnt_r <= store_cnt_r + 32'd1;
        end
    end

    assign load_cnt_o  = load_cnt_r;
    assign store_cnt_o = store_cnt_r;
`else
    assign load_cnt_o  = '0;
    assign store_cnt_o = '0;
`endif

endmodule

// File: tb/tb_ex_mem_reg.sv
// Self-checking bench for ex_mem_reg: directed vector table plus
// stall/flush, asynchronous reset and access-counter sequences.
module tb_ex_mem_reg;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        stall_i, flush_i, valid_i;
    logic [31:0] alu_res_i, st_data_i, pc4_i;
    logic        mem_we_i, mem_re_i, reg_we_i;
    logic [1:0]  mem_data_sel_i, wb_sel_i;
    logic [4:0]  rd_i;

    logic        valid_o, mem_we_o, reg_we_o, misalign_o, load_in_mem_o;
    logic [15:0] adr_o;
    logic [31:0] alu_res_o, st_data_o, pc4_o, load_cnt_o, store_cnt_o;
    logic [1:0]  mem_data_sel_o, wb_sel_o;
    logic [4:0]  rd_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    ex_mem_reg dut (
        .clk_i(clk_i), .reset_i(reset_i), .stall_i(stall_i), .flush_i(flush_i),
        .valid_i(valid_i), .alu_res_i(alu_res_i), .st_data_i(st_data_i),
        .mem_we_i(mem_we_i), .mem_re_i(mem_re_i), .mem_data_sel_i(mem_data_sel_i),
        .wb_sel_i(wb_sel_i), .reg_we_i(reg_we_i), .rd_i(rd_i), .pc4_i(pc4_i),
        .valid_o(valid_o), .adr_o(adr_o), .alu_res_o(alu_res_o),
        .st_data_o(st_data_o), .mem_we_o(mem_we_o), .mem_data_sel_o(mem_data_sel_o),
        .wb_sel_o(wb_sel_o), .reg_we_o(reg_we_o), .rd_o(rd_o), .pc4_o(pc4_o),
        .misalign_o(misalign_o), .load_in_mem_o(load_in_mem_o),
        .load_cnt_o(load_cnt_o), .store_cnt_o(store_cnt_o)
    );

    typedef struct {
        logic        v;
        logic [31:0] alu;
        logic [31:0] sd;
        logic        we;
        logic        re;
        logic [1:0]  sel;
        logic        rwe;
        logic [4:0]  rd;
    } in_t;

    typedef struct {
        logic        v;
        logic        we;
        logic        rwe;
        logic [4:0]  rd;
        logic        mis;
        logic        lim;
    } exp_t;

    typedef struct {
        in_t  i;
        exp_t e;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input in_t x, input logic st, input logic fl);
        stall_i        = st;
        flush_i        = fl;
        valid_i        = x.v;
        alu_res_i      = x.alu;
        st_data_i      = x.sd;
        mem_we_i       = x.we;
        mem_re_i       = x.re;
        mem_data_sel_i = x.sel;
        wb_sel_i       = x.re ? 2'b01 : 2'b00;
        reg_we_i       = x.rwe;
        rd_i           = x.rd;
        pc4_i          = x.alu + 32'd4;
    endtask

    task automatic step(input in_t x, input logic st, input logic fl);
        @(negedge clk_i);
        drive(x, st, fl);
        @(posedge clk_i);
        #1;
    endtask

    function automatic in_t mi(logic v, logic [31:0] alu, logic [31:0] sd, logic we,
                               logic re, logic [1:0] sel, logic rwe, logic [4:0] rd);
        in_t r;
        r.v = v; r.alu = alu; r.sd = sd; r.we = we; r.re = re;
        r.sel = sel; r.rwe = rwe; r.rd = rd;
        return r;
    endfunction

    function automatic exp_t me(logic v, logic we, logic rwe, logic [4:0] rd,
                                logic mis, logic lim);
        exp_t r;
        r.v = v; r.we = we; r.rwe = rwe; r.rd = rd; r.mis = mis; r.lim = lim;
        return r;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, " valid"}, {31'd0, valid_o}, 32'd0);
        chk({tag, " adr"}, {16'd0, adr_o}, 32'd0);
        chk({tag, " alu"}, alu_res_o, 32'd0);
        chk({tag, " st"}, st_data_o, 32'd0);
        chk({tag, " we"}, {31'd0, mem_we_o}, 32'd0);
        chk({tag, " rwe"}, {31'd0, reg_we_o}, 32'd0);
        chk({tag, " rd"}, {27'd0, rd_o}, 32'd0);
        chk({tag, " pc4"}, pc4_o, 32'd0);
        chk({tag, " sel"}, {30'd0, mem_data_sel_o}, 32'd0);
        chk({tag, " wb"}, {30'd0, wb_sel_o}, 32'd0);
        chk({tag, " mis"}, {31'd0, misalign_o}, 32'd0);
        chk({tag, " lim"}, {31'd0, load_in_mem_o}, 32'd0);
        chk({tag, " lcnt"}, load_cnt_o, 32'd0);
        chk({tag, " scnt"}, store_cnt_o, 32'd0);
    endtask

    vec_t vt[11];
    in_t  bub;

    initial begin
        // Vector table: {inputs} -> {expected after one edge}
        vt[0]  = '{mi(1, 32'h0000_4008, 32'h0, 0, 1, 2'b11, 1, 5),  me(1, 0, 1, 5, 0, 1)};
        vt[1]  = '{mi(1, 32'h0000_4002, 32'hDEAD_BEEF, 1, 0, 2'b11, 0, 0), me(1, 0, 0, 0, 1, 0)};
        vt[2]  = '{mi(1, 32'h0000_4004, 32'hCAFE_F00D, 1, 0, 2'b11, 0, 0), me(1, 1, 0, 0, 0, 0)};
        vt[3]  = '{mi(1, 32'h0000_4001, 32'h0000_1234, 1, 0, 2'b01, 0, 0), me(1, 0, 0, 0, 1, 0)};
        vt[4]  = '{mi(1, 32'h0000_4003, 32'h0000_00AB, 1, 0, 2'b00, 0, 0), me(1, 1, 0, 0, 0, 0)};
        vt[5]  = '{mi(1, 32'h0000_4000, 32'h0, 0, 1, 2'b10, 1, 7),  me(1, 0, 0, 0, 1, 0)};
        vt[6]  = '{mi(1, 32'h0000_4008, 32'h1111_2222, 1, 1, 2'b11, 0, 0), me(1, 1, 0, 0, 0, 0)};
        vt[7]  = '{mi(0, 32'h0000_4004, 32'h3333_4444, 1, 0, 2'b11, 1, 4), me(0, 0, 0, 0, 0, 0)};
        vt[8]  = '{mi(1, 32'h0000_4002, 32'h0, 0, 1, 2'b01, 1, 3),  me(1, 0, 1, 3, 0, 1)};
        vt[9]  = '{mi(1, 32'h0000_4003, 32'h0, 0, 1, 2'b01, 1, 3),  me(1, 0, 0, 0, 1, 0)};
        vt[10] = '{mi(1, 32'h0001_2345, 32'h0, 0, 0, 2'b10, 1, 9),  me(1, 0, 1, 9, 0, 0)};
        bub = mi(0, 32'h0, 32'h0, 0, 0, 2'b00, 0, 0);

        reset_i = 1'b1;
        drive(bub, 1'b0, 1'b0);
        #1;
        chk_all_zero("reset");
        @(negedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b0;

        for (int k = 0; k < 11; k++) begin
            step(vt[k].i, 1'b0, 1'b0);
            chk($sformatf("v%0d valid", k), {31'd0, valid_o}, {31'd0, vt[k].e.v});
            chk($sformatf("v%0d adr", k), {16'd0, adr_o}, {16'd0, vt[k].i.alu[15:0]});
            chk($sformatf("v%0d alu", k), alu_res_o, vt[k].i.alu);
            chk($sformatf("v%0d st", k), st_data_o, vt[k].i.sd);
            chk($sformatf("v%0d pc4", k), pc4_o, vt[k].i.alu + 32'd4);
            chk($sformatf("v%0d sel", k), {30'd0, mem_data_sel_o}, {30'd0, vt[k].i.sel});
            chk($sformatf("v%0d we", k), {31'd0, mem_we_o}, {31'd0, vt[k].e.we});
            chk($sformatf("v%0d rwe", k), {31'd0, reg_we_o}, {31'd0, vt[k].e.rwe});
            chk($sformatf("v%0d rd", k), {27'd0, rd_o}, {27'd0, vt[k].e.rd});
            chk($sformatf("v%0d mis", k), {31'd0, misalign_o}, {31'd0, vt[k].e.mis});
            chk($sformatf("v%0d lim", k), {31'd0, load_in_mem_o}, {31'd0, vt[k].e.lim});
        end

        // Stall: load at 0x4008 held for three cycles while inputs churn
        step(vt[0].i, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            step(mi(1, 32'h0000_5000 + c, 32'h9999_0000 + c, 1, 0, 2'b00, 1, 5'd20 + c[4:0]),
                 1'b1, 1'b0);
            chk($sformatf("stall%0d adr", c), {16'd0, adr_o}, 32'h0000_4008);
            chk($sformatf("stall%0d valid", c), {31'd0, valid_o}, 32'd1);
            chk($sformatf("stall%0d rd", c), {27'd0, rd_o}, 32'd5);
            chk($sformatf("stall%0d lim", c), {31'd0, load_in_mem_o}, 32'd1);
            chk($sformatf("stall%0d we", c), {31'd0, mem_we_o}, 32'd0);
            chk($sformatf("stall%0d st", c), st_data_o, 32'd0);
        end
        // Flush wins over a simultaneous stall
        step(vt[2].i, 1'b1, 1'b1);
        chk("flush valid", {31'd0, valid_o}, 32'd0);
        chk("flush we", {31'd0, mem_we_o}, 32'd0);
        chk("flush rwe", {31'd0, reg_we_o}, 32'd0);
        chk("flush lim", {31'd0, load_in_mem_o}, 32'd0);
        chk("flush rd", {27'd0, rd_o}, 32'd0);

        // Asynchronous reset arriving mid-stall, between edges
        step(vt[2].i, 1'b0, 1'b0);
        chk("pre-rst we", {31'd0, mem_we_o}, 32'd1);
        @(negedge clk_i);
        drive(vt[4].i, 1'b1, 1'b0);
        @(posedge clk_i);
        #2;
        reset_i = 1'b1;
        #1;
        chk_all_zero("async-rst");
        @(negedge clk_i);
        drive(bub, 1'b0, 1'b0);
        reset_i = 1'b0;

        // Access counters: 4 loads (one stalled a cycle), 2 stores, 1 misaligned store
        step(mi(1, 32'h0000_4000, 32'h0, 0, 1, 2'b11, 1, 1), 1'b0, 1'b0);
        step(mi(1, 32'h0000_4004, 32'h0, 0, 1, 2'b11, 1, 2), 1'b0, 1'b0);
        step(mi(1, 32'h0000_4100, 32'h0, 1, 0, 2'b11, 0, 0), 1'b1, 1'b0);
        chk("cnt-stall load", {31'd0, load_in_mem_o}, 32'd1);
        chk("cnt-stall adr", {16'd0, adr_o}, 32'h0000_4004);
        step(mi(1, 32'h0000_4008, 32'h0, 0, 1, 2'b11, 1, 3), 1'b0, 1'b0);
        step(mi(1, 32'h0000_400C, 32'h0, 0, 1, 2'b01, 1, 4), 1'b0, 1'b0);
        step(mi(1, 32'h0000_4010, 32'hA5A5_A5A5, 1, 0, 2'b11, 0, 0), 1'b0, 1'b0);
        step(mi(1, 32'h0000_4014, 32'h5A5A_5A5A, 1, 0, 2'b00, 0, 0), 1'b0, 1'b0);
        step(mi(1, 32'h0000_4016, 32'h0F0F_0F0F, 1, 0, 2'b11, 0, 0), 1'b0, 1'b0);
        chk("cnt mis-store", {31'd0, misalign_o}, 32'd1);
        step(bub, 1'b0, 1'b0);
        step(bub, 1'b0, 1'b0);
`ifdef MEM_ACCESS_CNT_EN
        chk("load_cnt", load_cnt_o, 32'd4);
        chk("store_cnt", store_cnt_o, 32'd2);
`else
        chk("load_cnt", load_cnt_o, 32'd0);
        chk("store_cnt", store_cnt_o, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
